// File: rtl/sc_io_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sc_io_pkg
// Brief    : Address map and helpers for the single-cycle computer I/O bank
// Revision : 1.0 - initial release
// ============================================================================
package sc_io_pkg;

    localparam logic [7:0] OUT_BASE    = 8'h80;
    localparam logic [7:0] IN_BASE     = 8'hC0;
    localparam logic [7:0] MASK_ADDR   = 8'hF8;
    localparam logic [7:0] STATUS_ADDR = 8'hFC;

    // Byte address to 32-bit word index; the two byte-lane bits are dropped.
    function automatic logic [5:0] word_idx(input logic [7:0] byte_addr);
        return 6'(byte_addr >> 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sc_io_debounce.sv
`default_nettype none
// ============================================================================
// Module   : sc_io_debounce
// Brief    : 2-flop synchronizer plus whole-vector debounce of one input port
// Revision : 1.0 - initial release
// ============================================================================
module sc_io_debounce
    import sc_io_pkg::*;
#(
    parameter int W          = 10,
    parameter int DEB_CYCLES = 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [W-1:0] raw,
    output logic [W-1:0] deb,
    output logic         changed_pulse
);

    // A single-cycle debounce still needs a 1-bit counter to stay legal.
    localparam int                 c_CNT_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEB_CYCLES - 1);

    logic [W-1:0]       r_s1;
    logic [W-1:0]       r_s2;
    logic [W-1:0]       r_deb;
    logic [c_CNT_W-1:0] r_cnt;

    // High on the edge where the new value is accepted into deb.
    assign changed_pulse = (r_s2 != r_deb) && (r_cnt == c_CNT_MAX);
    assign deb           = r_deb;

    // Bring the asynchronous port into the clock domain.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= raw;
            r_s2 <= r_s1;
        end
    end

    // Count consecutive mismatching cycles; any return to equality restarts.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
            r_deb <= '0;
        end else if (r_s2 == r_deb) begin
            r_cnt <= '0;
        end else if (r_cnt == c_CNT_MAX) begin
            r_deb <= r_s2;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sc_io_bank.sv
`default_nettype none
// ============================================================================
// Module   : sc_io_bank
// Brief    : Memory-mapped I/O bank: output ports, debounced input ports,
//            sticky change flags with W1C status and maskable interrupt
// Revision : 1.0 - initial release
// ============================================================================
module sc_io_bank
    import sc_io_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NUM_OUT    = 2,
    parameter int NUM_IN     = 2,
    parameter int IN_W       = 10,
    parameter int DEB_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [7:0]                addr,
    input  logic                      io_sel,
    input  logic                      we,
    input  logic [DATA_W-1:0]         wdata,
    output logic [DATA_W-1:0]         rdata,
    input  logic [NUM_IN*IN_W-1:0]    in_port,
    output logic [NUM_OUT*DATA_W-1:0] out_port,
    output logic                      irq
);

    localparam logic [5:0] c_OUT_IDX    = word_idx(OUT_BASE);
    localparam logic [5:0] c_IN_IDX     = word_idx(IN_BASE);
    localparam logic [5:0] c_MASK_IDX   = word_idx(MASK_ADDR);
    localparam logic [5:0] c_STATUS_IDX = word_idx(STATUS_ADDR);

    logic [5:0]        w_idx;
    logic [NUM_OUT-1:0] w_out_we;
    logic              w_mask_we;
    logic              w_status_we;
    logic [NUM_IN-1:0] w_set;
    logic [IN_W-1:0]   w_deb [NUM_IN];
    logic [DATA_W-1:0] w_rdata;

    logic [DATA_W-1:0] r_out [NUM_OUT];
    logic [NUM_IN-1:0] r_mask;
    logic [NUM_IN-1:0] r_flag;

    assign w_idx       = word_idx(addr);
    assign w_mask_we   = io_sel && we && (w_idx == c_MASK_IDX);
    assign w_status_we = io_sel && we && (w_idx == c_STATUS_IDX);

    generate
        for (genvar k = 0; k < NUM_OUT; k++) begin : g_out_port
            assign w_out_we[k]                  = io_sel && we && (w_idx == c_OUT_IDX + 6'(k));
            assign out_port[k*DATA_W +: DATA_W] = r_out[k];
        end

        for (genvar k = 0; k < NUM_IN; k++) begin : g_in_port
            sc_io_debounce #(
                .W          (IN_W),
                .DEB_CYCLES (DEB_CYCLES)
            ) u_debounce (
                .clk           (clk),
                .resetn        (resetn),
                .raw           (in_port[k*IN_W +: IN_W]),
                .deb           (w_deb[k]),
                .changed_pulse (w_set[k])
            );
        end
    endgenerate

    // Output port registers, one word each.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < NUM_OUT; k++) r_out[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_OUT; k++) begin
                if (w_out_we[k]) r_out[k] <= wdata;
            end
        end
    end

    // Interrupt mask register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)        r_mask <= '0;
        else if (w_mask_we) r_mask <= wdata[NUM_IN-1:0];
    end

    // Sticky change flags; a set in the same cycle as a W1C clear wins.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)          r_flag <= '0;
        else if (w_status_we) r_flag <= (r_flag & ~wdata[NUM_IN-1:0]) | w_set;
        else                  r_flag <= r_flag | w_set;
    end

    // Zero-latency read mux; anything not decoded reads as zero.
    always_comb begin
        w_rdata = '0;
        if (io_sel) begin
            for (int k = 0; k < NUM_OUT; k++) begin
                if (w_idx == c_OUT_IDX + 6'(k)) w_rdata = r_out[k];
            end
            for (int k = 0; k < NUM_IN; k++) begin
                if (w_idx == c_IN_IDX + 6'(k)) w_rdata = DATA_W'(w_deb[k]);
            end
            if (w_idx == c_MASK_IDX)   w_rdata = DATA_W'(r_mask);
            if (w_idx == c_STATUS_IDX) w_rdata = DATA_W'(r_flag);
        end
    end

    assign rdata = w_rdata;
    assign irq   = |(r_flag & r_mask);

endmodule
`default_nettype wire

// File: tb/tb_sc_io_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_sc_io_bank
// Brief    : Self-checking bench for sc_io_bank (vector table + scoreboard)
// Revision : 1.0 - initial release
// ============================================================================
module tb_sc_io_bank;

    localparam int DATA_W  = 32;
    localparam int NUM_OUT = 2;
    localparam int NUM_IN  = 2;
    localparam int IN_W    = 10;
    localparam int DEB     = 4;
    localparam int ACCEPT  = 2 + DEB;

    logic                      clk;
    logic                      resetn;
    logic [7:0]                addr;
    logic                      io_sel;
    logic                      we;
    logic [DATA_W-1:0]         wdata;
    logic [DATA_W-1:0]         rdata;
    logic [NUM_IN*IN_W-1:0]    in_port;
    logic [NUM_OUT*DATA_W-1:0] out_port;
    logic                      irq;

    sc_io_bank #(
        .DATA_W     (DATA_W),
        .NUM_OUT    (NUM_OUT),
        .NUM_IN     (NUM_IN),
        .IN_W       (IN_W),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .addr     (addr),
        .io_sel   (io_sel),
        .we       (we),
        .wdata    (wdata),
        .rdata    (rdata),
        .in_port  (in_port),
        .out_port (out_port),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [63:0] exp;
    } sb_t;

    typedef struct packed {
        logic        sel;
        logic        wr;
        logic [7:0]  a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic [63:0] exp_out;
    } vec_t;

    sb_t  sb_q [$];
    vec_t vecs [20];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic expect_val(input string name, input logic [63:0] exp);
        sb_q.push_back('{name, exp});
    endtask

    task automatic compare(input logic [63:0] act);
        sb_t e;
        n_tests++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got 0x%0h, expected nothing", act);
        end else begin
            e = sb_q.pop_front();
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, act, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_check(input string name, input logic sel, input logic [7:0] a,
                            input logic [31:0] exp);
        io_sel = sel;
        addr   = a;
        we     = 1'b0;
        expect_val(name, {32'h0, exp});
        #1;
        compare({32'h0, rdata});
    endtask

    task automatic irq_check(input string name, input logic exp);
        expect_val(name, {63'h0, exp});
        compare({63'h0, irq});
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        io_sel = 1'b1;
        we     = 1'b1;
        addr   = a;
        wdata  = d;
        tick();
        we     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] o0;
        logic [63:0] o2;
        o0 = {32'h0, 32'h1234_5678};
        o2 = {32'hDEAD_BEEF, 32'h1234_5678};
        //           sel   wr    addr   wdata          rd-same-cycle  out after edge
        vecs[0]  = '{1'b1, 1'b1, 8'h80, 32'h1234_5678, 32'h0,         o0};
        vecs[1]  = '{1'b1, 1'b1, 8'h84, 32'hDEAD_BEEF, 32'h0,         o2};
        vecs[2]  = '{1'b1, 1'b0, 8'h80, 32'h0,         32'h1234_5678, o2};
        vecs[3]  = '{1'b1, 1'b0, 8'h84, 32'h0,         32'hDEAD_BEEF, o2};
        vecs[4]  = '{1'b1, 1'b1, 8'hC0, 32'hFFFF_FFFF, 32'h0,         o2};
        vecs[5]  = '{1'b1, 1'b1, 8'h90, 32'hAAAA_5555, 32'h0,         o2};
        vecs[6]  = '{1'b0, 1'b1, 8'h80, 32'h0,         32'h0,         o2};
        vecs[7]  = '{1'b1, 1'b0, 8'h80, 32'h0,         32'h1234_5678, o2};
        vecs[8]  = '{1'b1, 1'b0, 8'hC0, 32'h0,         32'h0,         o2};
        vecs[9]  = '{1'b1, 1'b0, 8'h90, 32'h0,         32'h0,         o2};
        vecs[10] = '{1'b0, 1'b0, 8'h84, 32'h0,         32'h0,         o2};
        vecs[11] = '{1'b1, 1'b1, 8'hF8, 32'hFFFF_FFFF, 32'h0,         o2};
        vecs[12] = '{1'b1, 1'b0, 8'hF8, 32'h0,         32'h3,         o2};
        vecs[13] = '{1'b1, 1'b1, 8'hF8, 32'h0,         32'h3,         o2};
        vecs[14] = '{1'b1, 1'b0, 8'hF8, 32'h0,         32'h0,         o2};
        vecs[15] = '{1'b1, 1'b0, 8'hFC, 32'h0,         32'h0,         o2};
        vecs[16] = '{1'b1, 1'b0, 8'hBC, 32'h0,         32'h0,         o2};
        vecs[17] = '{1'b1, 1'b0, 8'hC8, 32'h0,         32'h0,         o2};
        vecs[18] = '{1'b1, 1'b1, 8'hFC, 32'hFFFF_FFFF, 32'h0,         o2};
        vecs[19] = '{1'b1, 1'b0, 8'hFC, 32'h0,         32'h0,         o2};

        resetn  = 1'b0;
        io_sel  = 1'b0;
        we      = 1'b0;
        addr    = 8'h0;
        wdata   = '0;
        in_port = '0;

        // Reset state
        tick();
        tick();
        rd_check("reset_rd_80", 1'b1, 8'h80, 32'h0);
        rd_check("reset_rd_f8", 1'b1, 8'hF8, 32'h0);
        rd_check("reset_rd_fc", 1'b1, 8'hFC, 32'h0);
        expect_val("reset_out_port", 64'h0);
        compare(out_port);
        irq_check("reset_irq", 1'b0);
        resetn = 1'b1;
        tick();

        // Register map vectors: same-cycle read, then state after the edge
        for (int i = 0; i < 20; i++) begin
            io_sel = vecs[i].sel;
            we     = vecs[i].wr;
            addr   = vecs[i].a;
            wdata  = vecs[i].d;
            expect_val($sformatf("vec%0d_rdata", i), {32'h0, vecs[i].exp_rd});
            #1;
            compare({32'h0, rdata});
            tick();
            we = 1'b0;
            expect_val($sformatf("vec%0d_out_port", i), vecs[i].exp_out);
            compare(out_port);
        end

        // Port0 held change: accepted exactly at edge 2+DEB
        in_port[IN_W-1:0] = 10'h2A5;
        for (int e = 1; e <= ACCEPT + 1; e++) begin
            tick();
            rd_check($sformatf("in0_edge%0d", e), 1'b1, 8'hC0,
                     (e >= ACCEPT) ? 32'h2A5 : 32'h0);
            rd_check($sformatf("status_edge%0d", e), 1'b1, 8'hFC,
                     (e >= ACCEPT) ? 32'h1 : 32'h0);
            irq_check($sformatf("irq_unmasked_edge%0d", e), 1'b0);
        end

        // Port1 3-cycle glitch must never be accepted
        in_port[2*IN_W-1:IN_W] = 10'h3FF;
        tick();
        tick();
        tick();
        in_port[2*IN_W-1:IN_W] = 10'h0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            rd_check($sformatf("glitch_in1_%0d", e), 1'b1, 8'hC4, 32'h0);
            rd_check($sformatf("glitch_status_%0d", e), 1'b1, 8'hFC, 32'h1);
        end

        // Masked port1 change raises irq
        wr(8'hF8, 32'h2);
        in_port[2*IN_W-1:IN_W] = 10'h3FF;
        for (int e = 1; e <= ACCEPT; e++) begin
            tick();
            irq_check($sformatf("irq_edge%0d", e), e >= ACCEPT);
            rd_check($sformatf("in1_edge%0d", e), 1'b1, 8'hC4,
                     (e >= ACCEPT) ? 32'h3FF : 32'h0);
        end

        // W1C clears flag1 and irq on the next edge
        wr(8'hFC, 32'h2);
        irq_check("irq_after_w1c", 1'b0);
        rd_check("status_after_w1c", 1'b1, 8'hFC, 32'h1);

        // New accepted change on the same edge as a W1C: set wins
        in_port[2*IN_W-1:IN_W] = 10'h0;
        for (int e = 1; e < ACCEPT; e++) begin
            tick();
            irq_check($sformatf("irq_pre_coincide_%0d", e), 1'b0);
        end
        io_sel = 1'b1;
        we     = 1'b1;
        addr   = 8'hFC;
        wdata  = 32'h2;
        tick();
        we = 1'b0;
        irq_check("irq_coincide", 1'b1);
        rd_check("status_coincide", 1'b1, 8'hFC, 32'h3);

        // Asynchronous reset with port0 mid-count (cnt=2 after edge 4)
        in_port[IN_W-1:0] = 10'h155;
        for (int e = 1; e <= 4; e++) tick();
        #2;
        resetn = 1'b0;
        #1;
        expect_val("async_rst_out_port", 64'h0);
        compare(out_port);
        irq_check("async_rst_irq", 1'b0);
        rd_check("async_rst_mask", 1'b1, 8'hF8, 32'h0);
        rd_check("async_rst_status", 1'b1, 8'hFC, 32'h0);
        rd_check("async_rst_in0", 1'b1, 8'hC0, 32'h0);
        tick();
        tick();
        resetn = 1'b1;
        for (int e = 1; e <= ACCEPT; e++) begin
            tick();
            rd_check($sformatf("post_rst_status_%0d", e), 1'b1, 8'hFC,
                     (e >= ACCEPT) ? 32'h1 : 32'h0);
            rd_check($sformatf("post_rst_in0_%0d", e), 1'b1, 8'hC0,
                     (e >= ACCEPT) ? 32'h155 : 32'h0);
        end
        irq_check("post_rst_irq_masked", 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
